// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART FSM states and oversampling constants
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int BIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_ERR
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
// Write on full and read on empty are ignored; full is judged before a same-cycle read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - full-duplex 16x-oversampled UART with TX/RX FIFOs
// Optional parity bit on both directions when UART_PARITY_EN is defined.
module uart_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 rx,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_parity_err
);

  import uart_pkg::*;

  localparam logic [15:0]          DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0]    LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0]    MID_TICK  = TICK_W'(MID_SAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

  logic [15:0] div_q, div_d;
  logic        tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 16'd1;

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  logic                 tx_fifo_empty, tx_fifo_full, tx_pop;
  logic [DATA_BITS-1:0] tx_fifo_data;
  logic                 rx_fifo_empty, rx_fifo_full, rx_push;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (tx_valid),
    .wr_data_i (tx_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_fifo_data),
    .full_o    (tx_fifo_full),
    .empty_o   (tx_fifo_empty)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (rx_push),
    .wr_data_i (rx_shift_q),
    .rd_en_i   (rx_ready),
    .rd_data_o (rx_data),
    .full_o    (rx_fifo_full),
    .empty_o   (rx_fifo_empty)
  );

  assign tx_ready = !tx_fifo_full;
  assign rx_valid = !rx_fifo_empty;

  // ---------------- receiver ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [TICK_W-1:0]    rx_tcnt_q, rx_tcnt_d;
  logic [BIT_CNT_W-1:0] rx_bits_q, rx_bits_d;
  logic                 frame_err;
`ifdef UART_PARITY_EN
  logic                 rx_par_bad_q, rx_par_bad_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frame_err  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
`endif
    if (tick) begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_d = RX_START;
            rx_tcnt_d  = '0;
          end
        end
        RX_START: begin
          // Mid-start re-check rejects glitches shorter than half a bit.
          if (rx_tcnt_q == MID_TICK) begin
            rx_tcnt_d  = '0;
            rx_bits_d  = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tcnt_q == LAST_TICK) begin
            rx_tcnt_d  = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bits_d  = rx_bits_q + 1'b1;
            if (rx_bits_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state_d = RX_PARITY;
`else
              rx_state_d = RX_STOP;
`endif
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_tcnt_q == LAST_TICK) begin
            rx_tcnt_d    = '0;
            rx_par_bad_d = rx_sync_q != ((^rx_shift_q) ^ PARITY_ODD[0]);
            rx_state_d   = RX_STOP;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_tcnt_q == LAST_TICK) begin
            rx_tcnt_d = '0;
            if (rx_sync_q) begin
              rx_push    = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              frame_err  = 1'b1;
              rx_state_d = RX_ERR;
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 1'b1;
          end
        end
        RX_ERR: begin
          if (rx_sync_q) rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_frame_err = frame_err;
  assign rx_overrun   = rx_push && rx_fifo_full;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_push && rx_par_bad_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
  assign rx_parity_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bits_q  <= '0;
      rx_shift_q <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
      rx_par_bad_q <= rx_par_bad_d;
`endif
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [TICK_W-1:0]    tx_tcnt_q, tx_tcnt_d;
  logic [BIT_CNT_W-1:0] tx_bits_q, tx_bits_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    if (tick) begin
      unique case (tx_state_q)
        TX_IDLE: begin
          if (!tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_fifo_data;
            tx_tcnt_d  = '0;
            tx_state_d = TX_START;
`ifdef UART_PARITY_EN
            tx_par_d = (^tx_fifo_data) ^ PARITY_ODD[0];
`endif
          end
        end
        TX_START: begin
          if (tx_tcnt_q == LAST_TICK) begin
            tx_tcnt_d  = '0;
            tx_bits_d  = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_tcnt_q == LAST_TICK) begin
            tx_tcnt_d  = '0;
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_bits_d  = tx_bits_q + 1'b1;
            if (tx_bits_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
              tx_state_d = TX_PARITY;
`else
              tx_state_d = TX_STOP;
`endif
            end
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_tcnt_q == LAST_TICK) begin
            tx_tcnt_d  = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (tx_tcnt_q == LAST_TICK) begin
            tx_tcnt_d = '0;
            if (!tx_fifo_empty) begin
              tx_pop     = 1'b1;
              tx_shift_d = tx_fifo_data;
              tx_state_d = TX_START;
`ifdef UART_PARITY_EN
              tx_par_d = (^tx_fifo_data) ^ PARITY_ODD[0];
`endif
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_tcnt_d = tx_tcnt_q + 1'b1;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end

    unique case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_d = tx_par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bits_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
`ifdef UART_PARITY_EN
      tx_par_q <= tx_par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE) || !tx_fifo_empty;

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised full-duplex UART with 16x oversampling, runtime-independent TX/RX buffering and valid/ready byte interfaces. It replaces the fixed 8N1, fixed-baud, unbuffered UART in the SoC peripheral set. It sits between the CPU I/O bus glue (byte streams) and the board `rx`/`tx` pins, and reports framing, overrun and (optionally) parity errors.

## Interface
- `CLK_DIV`, 104: clk cycles per oversample tick; bit period = 16*CLK_DIV clk cycles (legal 2..65535).
- `DATA_BITS`, 8: data bits per frame (legal 5..8).
- `FIFO_DEPTH`, 16: entries per TX and RX FIFO, power of two, >= 2.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even; only meaningful with `UART_PARITY_EN`.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  tx_data valid.
- `tx_ready`  out  1  TX FIFO not full.
- `rx_data`  out  DATA_BITS  head of RX FIFO (first-word fall-through).
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  consumer pops head.
- `rx`  in  1  serial input, asynchronous.
- `tx`  out  1  serial output, idles high.
- `tx_busy`  out  1  TX FSM not IDLE or TX FIFO not empty.
- `rx_frame_err`  out  1  one-clk pulse: stop bit sampled low.
- `rx_overrun`  out  1  one-clk pulse: received word dropped, RX FIFO full.
- `rx_parity_err`  out  1  one-clk pulse: parity mismatch (constant 0 without macro).

## Operation
- Tick generator: counter 0..CLK_DIV-1, `tick` asserted for one clk at wrap.
- `rx` passes a 2-flop synchroniser clocked every clk (reset value 1).
- RX FSM (advances on `tick` only): IDLE -> START on synced rx=0; START: at 8th tick re-sample, 0 -> DATA, 1 -> IDLE (glitch reject). DATA: sample every 16 ticks, LSB first, DATA_BITS samples -> PARITY (macro) or STOP. PARITY: sample, compare -> STOP. STOP: sample at 16 ticks; 1 -> push word, IDLE; 0 -> `rx_frame_err`, word discarded, ERR. ERR -> IDLE when synced rx=1.
- Parity mismatch: word still pushed, `rx_parity_err` pulsed on push cycle.
- Push with RX FIFO full: word dropped, `rx_overrun` pulsed; FIFO contents unchanged.
- TX FSM: IDLE pops FIFO when non-empty on a tick, drives start bit; START, DATA (LSB first), PARITY (macro), STOP each last exactly 16 ticks; STOP -> IDLE, next byte may start on the following tick (back-to-back frames, no gap).
- Handshakes: TX write on `tx_valid && tx_ready` edge; RX pop on `rx_valid && rx_ready` edge; pop on empty and write on full are ignored.
- FIFO full + simultaneous pop/push: push rejected (full evaluated before pop). Empty + simultaneous push/pop: pop ignored. Pointers wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1.

## Timing
- Reset (async assert, sync release): `tx`=1, `tx_ready`=1, `rx_valid`=0, `tx_busy`=0, all error pulses 0, FSMs IDLE, FIFOs empty, prescaler 0. Reset mid-frame aborts frame; `tx` returns high immediately.
- `tx_ready` deasserts the clk after the write that fills the FIFO.
- TX latency: byte written into empty FIFO with FSM idle -> `tx` falls within CLK_DIV+1 clks.
- RX: `rx_valid` rises 1 clk after the STOP-sample tick.
- Frame length = (2 + DATA_BITS + P)*16 ticks, P = 1 with macro else 0.

## Configuration
- `UART_PARITY_EN` defined: one parity bit after data on TX and RX, polarity from `PARITY_ODD`; `rx_parity_err` live.
- Undefined: no parity state in either FSM, frame is 8N1-style (DATA_BITS N 1), `rx_parity_err` tied 0.

## Structure
- Package `uart_pkg`: RX/TX state enums, `OVERSAMPLE`=16, `MID_SAMPLE`=8, tick-count width.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; FWFT; full/empty), instantiated for TX and RX.

## Test plan
- CLK_DIV=4, DATA_BITS=8, no parity: write 0x41 -> `tx` low 64 clks, bits 1,0,0,0,0,0,1,0 at 64 clks each, high stop 64 clks.
- Loopback `tx`->`rx`, write 0x00,0xFF,0xA5 back-to-back -> `rx_data` pops same three in order, no error pulses, no idle gap on `tx`.
- 20 bytes into RX with `rx_ready`=0, FIFO_DEPTH=16 -> 16 stored, `rx_overrun` pulses 4 times, first 16 bytes intact.
- Drive frame 0x55 with stop bit low -> `rx_frame_err` one pulse, no push; rx held low then high -> next 0x33 received correctly.
- 1-tick low glitch on `rx` -> RX returns IDLE, no push, no error.
- With `UART_PARITY_EN`, PARITY_ODD=0: send 0x07 with parity bit 0 -> pushed 0x07, `rx_parity_err` pulses; assert `rst` mid-TX -> `tx`=1 same cycle, `tx_busy`=0.
